// File: rtl/hid_report_pkg.sv
// Shared types and constants for hid_report_reader.
// Defining HID_WHEEL_EN appends the wheel delta byte to the report.
package hid_report_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_FREEZE  = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_SEND    = 2'd3;

  // Two synchronizer flops in the HID source plus one settle cycle
  localparam int unsigned FREEZE_CYCLES = 3;

  localparam int unsigned BYTE_CONN    = 0;
  localparam int unsigned BYTE_MODS    = 1;
  localparam int unsigned BYTE_KEY0    = 2;
  localparam int unsigned BYTE_BUTTONS = 8;
  localparam int unsigned BYTE_DX      = 9;
  localparam int unsigned BYTE_DY      = 10;
  localparam int unsigned BYTE_DWHEEL  = 11;

`ifdef HID_WHEEL_EN
  localparam int unsigned REPORT_LEN = 12;
`else
  localparam int unsigned REPORT_LEN = 11;
`endif

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 2;

endpackage

// File: rtl/hid_report_reader_sat_delta.sv
// Per-axis delta: wrap-aware difference from the last reported position,
// saturated to int8; the reported amount is accumulated so residuals carry over.
module hid_sat_delta8 (
  input  logic               clk_48m,
  input  logic               reset,
  input  logic               en,
  input  logic signed [31:0] cur,
  output logic        [7:0]  delta_c
);

  logic signed [31:0] last_q;
  logic signed [32:0] diff33;
  logic signed [31:0] diff;
  logic signed [7:0]  sat;
  logic               unused_borrow;

  // Source counters wrap, so the difference is folded back to 32 bits before saturating
  always_comb begin
    diff33 = 33'(cur) - 33'(last_q);
    diff   = diff33[31:0];
    if (diff > 32'sd127) begin
      sat = 8'sd127;
    end else if (diff < -32'sd128) begin
      sat = -8'sd128;
    end else begin
      sat = diff[7:0];
    end
  end

  assign unused_borrow = diff33[32];
  assign delta_c       = sat;

  always_ff @(posedge clk_48m) begin
    if (reset) begin
      last_q <= 32'sd0;
    end else if (en) begin
      last_q <= last_q + 32'(sat);
    end
  end

endmodule

// File: rtl/hid_report_reader.sv
// Freezes the HID register source, snapshots it and streams one report as bytes.
// Optional wheel byte enabled by defining HID_WHEEL_EN.
module hid_report_reader
  import hid_report_pkg::*;
(
  input  logic                  clk_48m,
  input  logic                  reset,
  input  logic                  req,
  output logic                  busy,
  output logic                  hid_read,
  input  logic                  hid_keyboard_connected,
  input  logic                  hid_mouse_connected,
  input  logic [7:0]            hid_keyboard_modifiers,
  input  logic [5:0][7:0]       hid_keyboard_keycodes,
  input  logic [7:0]            hid_mouse_buttons,
  input  logic signed [31:0]    hid_mouse_x,
  input  logic signed [31:0]    hid_mouse_y,
  input  logic signed [31:0]    hid_mouse_wheel,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d, idx_inc;
  logic             busy_d, hid_read_d, valid_d, last_d;
  logic [7:0]       data_d;
  logic             capture_en;
  logic [7:0]       dx, dy;
  logic [7:0]       rpt      [REPORT_LEN];
  logic [7:0]       rpt_next [REPORT_LEN];

  hid_sat_delta8 u_dx (.clk_48m(clk_48m), .reset(reset), .en(capture_en), .cur(hid_mouse_x), .delta_c(dx));
  hid_sat_delta8 u_dy (.clk_48m(clk_48m), .reset(reset), .en(capture_en), .cur(hid_mouse_y), .delta_c(dy));

`ifdef HID_WHEEL_EN
  logic [7:0] dw;
  hid_sat_delta8 u_dw (.clk_48m(clk_48m), .reset(reset), .en(capture_en), .cur(hid_mouse_wheel), .delta_c(dw));
`else
  logic unused_wheel;
  assign unused_wheel = ^hid_mouse_wheel;
`endif

  // Report image as it would be captured this cycle
  always_comb begin
    rpt_next[BYTE_CONN]    = {hid_keyboard_connected, hid_mouse_connected, 6'b0};
    rpt_next[BYTE_MODS]    = hid_keyboard_modifiers;
    for (int k = 0; k < 6; k++) begin
      rpt_next[BYTE_KEY0 + k] = hid_keyboard_keycodes[k];
    end
    rpt_next[BYTE_BUTTONS] = hid_mouse_buttons;
    rpt_next[BYTE_DX]      = dx;
    rpt_next[BYTE_DY]      = dy;
`ifdef HID_WHEEL_EN
    rpt_next[BYTE_DWHEEL]  = dw;
`endif
  end

  assign idx_inc = idx + IDX_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    idx_d      = idx;
    busy_d     = busy;
    hid_read_d = hid_read;
    valid_d    = out_valid;
    last_d     = out_last;
    data_d     = out_data;
    capture_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_FREEZE;
          cnt_d      = '0;
          busy_d     = 1'b1;
          hid_read_d = 1'b1;
        end
      end
      ST_FREEZE: begin
        if (cnt == CNT_W'(FREEZE_CYCLES - 1)) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        capture_en = 1'b1;
        state_d    = ST_SEND;
        hid_read_d = 1'b0;
        valid_d    = 1'b1;
        idx_d      = '0;
        data_d     = rpt_next[BYTE_CONN];
        last_d     = 1'b0;
      end
      default: begin
        if (out_valid && out_ready) begin
          if (idx == IDX_W'(REPORT_LEN - 1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            data_d  = 8'h00;
            idx_d   = '0;
          end else begin
            idx_d  = idx_inc;
            data_d = rpt[idx_inc];
            last_d = (idx_inc == IDX_W'(REPORT_LEN - 1));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_48m) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      hid_read  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 8'h00;
      for (int i = 0; i < int'(REPORT_LEN); i++) begin
        rpt[i] <= 8'h00;
      end
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      busy      <= busy_d;
      hid_read  <= hid_read_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      out_data  <= data_d;
      if (capture_en) begin
        for (int i = 0; i < int'(REPORT_LEN); i++) begin
          rpt[i] <= rpt_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_hid_report_reader.sv
// Self-checking bench for hid_report_reader; honours HID_WHEEL_EN like the design.
module tb_hid_report_reader;

`ifdef HID_WHEEL_EN
  localparam int TB_LEN = 12;
  localparam bit TB_WHEEL = 1'b1;
`else
  localparam int TB_LEN = 11;
  localparam bit TB_WHEEL = 1'b0;
`endif

  logic               clk_48m = 1'b0;
  logic               reset = 1'b1;
  logic               req = 1'b0;
  logic               busy, hid_read;
  logic               kbd_conn = 1'b0, mouse_conn = 1'b0;
  logic [7:0]         mods = 8'h00, buttons = 8'h00;
  logic [5:0][7:0]    keys = '0;
  logic signed [31:0] mx = 0, my = 0, mw = 0;
  logic [7:0]         out_data;
  logic               out_valid, out_last;
  logic               out_ready = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  int m_last_x = 0, m_last_y = 0, m_last_w = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         got_last[$];
  int hr_cycles, send_cycles, stall_errs, timed_out;
  logic end_valid, busy_start;

  always #10 clk_48m = ~clk_48m;

  hid_report_reader dut (
    .clk_48m(clk_48m), .reset(reset), .req(req), .busy(busy), .hid_read(hid_read),
    .hid_keyboard_connected(kbd_conn), .hid_mouse_connected(mouse_conn),
    .hid_keyboard_modifiers(mods), .hid_keyboard_keycodes(keys),
    .hid_mouse_buttons(buttons), .hid_mouse_x(mx), .hid_mouse_y(my), .hid_mouse_wheel(mw),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  function automatic logic [7:0] sat8(input int d);
    if (d > 127) return 8'h7F;
    if (d < -128) return 8'h80;
    return d[7:0];
  endfunction

  // Reference: expected report from the current inputs, advancing the model's positions
  task automatic model_report();
    logic [7:0] s;
    exp_q.delete();
    exp_q.push_back({kbd_conn, mouse_conn, 6'b0});
    exp_q.push_back(mods);
    for (int k = 0; k < 6; k++) exp_q.push_back(keys[k]);
    exp_q.push_back(buttons);
    s = sat8(int'(mx) - m_last_x); exp_q.push_back(s); m_last_x += int'($signed(s));
    s = sat8(int'(my) - m_last_y); exp_q.push_back(s); m_last_y += int'($signed(s));
    if (TB_WHEEL) begin
      s = sat8(int'(mw) - m_last_w); exp_q.push_back(s); m_last_w += int'($signed(s));
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = 1'b0;
    repeat (2) @(posedge clk_48m);
    #1;
    reset = 1'b0;
    m_last_x = 0; m_last_y = 0; m_last_w = 0;
  endtask

  // mode 0: ready held high, 1: ready toggles 1/0, 2: random ready; poke pulses req in FREEZE/SEND/last byte
  task automatic do_transfer(input int mode, input bit poke);
    int  vcount, cyc;
    bit  seen_valid, prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    got_q.delete(); got_last.delete();
    hr_cycles = 0; send_cycles = 0; stall_errs = 0; timed_out = 0;
    vcount = 0; seen_valid = 0; prev_stall = 0; prev_data = 8'h00; prev_last = 1'b0;
    req = 1'b1;
    @(posedge clk_48m); #1;
    req = 1'b0;
    busy_start = busy;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (seen_valid && !busy) break;
      req = 1'b0;
      if (hid_read) hr_cycles++;
      if (out_valid) begin
        seen_valid = 1;
        send_cycles++;
        if (prev_stall && (out_data !== prev_data || out_last !== prev_last)) stall_errs++;
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = (vcount % 2 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        vcount++;
        if (out_ready) begin
          got_q.push_back(out_data);
          got_last.push_back(out_last);
        end
        prev_stall = !out_ready; prev_data = out_data; prev_last = out_last;
        if (poke && (vcount == 1 || (out_ready && out_last))) req = 1'b1;
      end else if (poke && cyc == 1) begin
        req = 1'b1;
      end
      @(posedge clk_48m); #1;
    end
    if (cyc == 300) timed_out = 1;
    req = 1'b0;
    out_ready = 1'b1;
    end_valid = out_valid;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if ({busy, hid_read, out_valid, out_last} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {busy, hid_read, out_valid, out_last});
    end
    n_cmp++; if (out_data !== 8'h00) begin
      n_err++; $display("FAIL reset_data: got %h want 00", out_data);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    kbd_conn = 1; mouse_conn = 0; mods = 8'h02; keys = '0; keys[0] = 8'h04;
    buttons = 8'h00; mx = 5; my = -3; mw = 0;
    model_report();
    do_transfer(0, 0);
    n_cmp++; if (busy_start !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy_start); end
    n_cmp++; if (timed_out != 0 || got_q.size() != TB_LEN) begin
      n_err++; $display("FAIL basic_len: got %0d bytes (timeout %0d) want %0d", got_q.size(), timed_out, TB_LEN);
    end
    for (int i = 0; i < TB_LEN && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i] || got_last[i] !== (i == TB_LEN - 1)) begin
        n_err++; $display("FAIL basic_byte%0d: got %h/last %b want %h/last %b", i, got_q[i], got_last[i], exp_q[i], i == TB_LEN - 1);
      end
    end
    n_cmp++; if (got_q.size() > 10 && (got_q[0] !== 8'h80 || got_q[9] !== 8'h05 || got_q[10] !== 8'hFD)) begin
      n_err++; $display("FAIL basic_literal: got %h %h %h want 80 05 fd", got_q[0], got_q[9], got_q[10]);
    end
    n_cmp++; if (hr_cycles != 4) begin n_err++; $display("FAIL basic_hid_read: got %0d cycles want 4", hr_cycles); end
    n_cmp++; if (send_cycles != TB_LEN) begin n_err++; $display("FAIL basic_send_cycles: got %0d want %0d", send_cycles, TB_LEN); end
    n_cmp++; if (end_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", end_valid); end
  endtask

  task automatic test_saturation();
    logic [7:0] want_dx [4];
    want_dx = '{8'h7F, 8'h7F, 8'h2E, 8'h00};
    apply_reset();
    mx = 300; my = 0; mw = 0;
    for (int r = 0; r < 4; r++) begin
      model_report();
      do_transfer(0, 0);
      n_cmp++; if (got_q.size() != TB_LEN || got_q[9] !== want_dx[r] || exp_q[9] !== want_dx[r]) begin
        n_err++; $display("FAIL sat_dx%0d: got %h want %h", r, got_q.size() > 9 ? got_q[9] : 8'hxx, want_dx[r]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    kbd_conn = 1; mouse_conn = 1; mods = 8'hA5; buttons = 8'h03;
    for (int k = 0; k < 6; k++) keys[k] = 8'($urandom());
    mx = -50; my = 77; mw = 9;
    model_report();
    do_transfer(1, 0);
    n_cmp++; if (send_cycles != 2 * TB_LEN - 1) begin
      n_err++; $display("FAIL bp_cycles: got %0d want %0d", send_cycles, 2 * TB_LEN - 1);
    end
    n_cmp++; if (stall_errs != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_errs); end
    for (int i = 0; i < TB_LEN; i++) begin
      n_cmp++; if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bp_byte%0d: got %h want %h", i, got_q.size() > i ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want_dy [3];
    logic signed [31:0] ys [3];
    want_dy = '{8'hFF, 8'h02, 8'h7F};
    ys = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    apply_reset();
    mx = 0; mw = 0;
    for (int r = 0; r < 3; r++) begin
      my = ys[r];
      model_report();
      do_transfer(0, 0);
      n_cmp++; if (got_q.size() != TB_LEN || got_q[10] !== want_dy[r] || exp_q[10] !== want_dy[r]) begin
        n_err++; $display("FAIL wrap_dy%0d: got %h want %h", r, got_q.size() > 10 ? got_q[10] : 8'hxx, want_dy[r]);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    int acc, cyc;
    apply_reset();
    mx = 40; my = 0; mw = 0;
    acc = 0; cyc = 0;
    out_ready = 1'b1;
    req = 1'b1; @(posedge clk_48m); #1; req = 1'b0;
    while (acc < 5 && cyc < 100) begin
      if (out_valid) acc++;
      @(posedge clk_48m); #1;
      cyc++;
    end
    n_cmp++; if (acc != 5) begin n_err++; $display("FAIL rst_mid_reach: got %0d bytes want 5", acc); end
    reset = 1'b1;
    @(posedge clk_48m); #1;
    n_cmp++; if ({out_valid, busy, hid_read, out_last} !== 4'b0000 || out_data !== 8'h00) begin
      n_err++; $display("FAIL rst_mid_outputs: got %b/%h want 0000/00", {out_valid, busy, hid_read, out_last}, out_data);
    end
    reset = 1'b0;
    m_last_x = 0; m_last_y = 0; m_last_w = 0;
    mx = 10;
    model_report();
    do_transfer(0, 0);
    n_cmp++; if (got_q.size() != TB_LEN || got_q[9] !== 8'h0A) begin
      n_err++; $display("FAIL rst_mid_dx: got %h want 0a", got_q.size() > 9 ? got_q[9] : 8'hxx);
    end
  endtask

  task automatic test_ignored_req();
    int extra;
    apply_reset();
    mx = 3; my = 4; mw = -2;
    model_report();
    do_transfer(0, 1);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid || busy || hid_read) extra++;
      @(posedge clk_48m); #1;
    end
    n_cmp++; if (got_q.size() != TB_LEN) begin n_err++; $display("FAIL ign_len: got %0d want %0d", got_q.size(), TB_LEN); end
    n_cmp++; if (extra != 0) begin n_err++; $display("FAIL ign_second_report: got %0d active cycles want 0", extra); end
    for (int i = 0; i < TB_LEN && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL ign_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int r = 0; r < 15; r++) begin
      kbd_conn = 1'($urandom()); mouse_conn = 1'($urandom());
      mods = 8'($urandom()); buttons = 8'($urandom());
      for (int k = 0; k < 6; k++) keys[k] = 8'($urandom());
      mx = $urandom_range(0, 1) ? 32'($urandom()) : 32'(m_last_x + int'($urandom_range(0, 400)) - 200);
      my = $urandom_range(0, 1) ? 32'($urandom()) : 32'(m_last_y + int'($urandom_range(0, 400)) - 200);
      mw = $urandom_range(0, 1) ? 32'($urandom()) : 32'(m_last_w + int'($urandom_range(0, 400)) - 200);
      model_report();
      do_transfer(2, 0);
      n_cmp++; if (timed_out != 0 || stall_errs != 0 || got_q.size() != TB_LEN) begin
        n_err++; $display("FAIL rand%0d_xfer: got len %0d stalls %0d timeout %0d want %0d/0/0", r, got_q.size(), stall_errs, timed_out, TB_LEN);
      end
      for (int i = 0; i < TB_LEN && i < got_q.size(); i++) begin
        n_cmp++; if (got_q[i] !== exp_q[i] || got_last[i] !== (i == TB_LEN - 1)) begin
          n_err++; $display("FAIL rand%0d_byte%0d: got %h/%b want %h/%b", r, i, got_q[i], got_last[i], exp_q[i], i == TB_LEN - 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_wrap();
    test_reset_mid_send();
    test_ignored_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hid_report_reader.md
HID_REPORT_READER -- requirements
Module: hid_report_reader

Interface
REQ-001 SHALL have clock and reset as its first ports: clock `clk_48m` (input, 1); reset `reset` (input, 1), synchronous, active-high.
REQ-002 SHALL have `req` (input, 1): one-cycle pulse that starts one report transfer.
REQ-003 SHALL have `busy` (output, 1): high from the cycle after an accepted req until the last byte is accepted.
REQ-004 SHALL have `hid_read` (output, 1): freeze request to the HID register source; high means the source holds its outputs.
REQ-005 SHALL have these HID snapshot inputs: `hid_keyboard_connected` (1), `hid_mouse_connected` (1), `hid_keyboard_modifiers` (8), `hid_keyboard_keycodes` (6x8), `hid_mouse_buttons` (8), and signed `hid_mouse_x`, `hid_mouse_y`, `hid_mouse_wheel` (32 each).
REQ-006 SHALL have a byte-stream output: `out_data` (output, 8), `out_valid` (output, 1), `out_ready` (input, 1), `out_last` (output, 1).

Function
REQ-007 SHALL implement the states IDLE -> FREEZE -> CAPTURE -> SEND -> IDLE.
REQ-008 In IDLE, `req`=1 SHALL enter FREEZE and assert `hid_read` on the next cycle; `req` is ignored in every other state.
REQ-009 SHALL remain in FREEZE for exactly 3 cycles (this covers the source's 2-flop synchronizer plus one settle cycle), then enter CAPTURE.
REQ-010 CAPTURE (1 cycle) SHALL register all HID inputs into a report buffer, compute deltas, deassert `hid_read` on the next cycle, then enter SEND.
REQ-011 Delta for each axis SHALL be computed as d = input - last, saturated to the signed 8-bit range [-128, 127]; `last` then becomes `last` + saturated d, so the residual carries into the next report.
REQ-012 Report byte order SHALL be:
- byte 0 = {kbd_conn, mouse_conn, 6'b0}
- byte 1 = modifiers
- bytes 2-7 = keycodes[0..5]
- byte 8 = buttons
- byte 9 = dx
- byte 10 = dy
- byte 11 = dwheel (present only when HID_WHEEL_EN is defined; see REQ-020)
REQ-013 Bytes transfer when `out_valid` && `out_ready`; `out_data` and `out_last` SHALL hold stable while `out_valid` && !`out_ready`.
REQ-014 `out_valid` SHALL rise on the first SEND cycle and deassert the cycle after the final byte is accepted; `out_last` SHALL be high only with the final byte.
REQ-015 Back-to-back transfers SHALL sustain one byte per cycle when `out_ready` is held high; a full report therefore takes REPORT_LEN cycles in SEND.
REQ-016 Subtraction SHALL be 33-bit signed so that wrap of the 32-bit source counters yields the correct small delta (e.g. last=0x7FFFFFFF, input=0x80000001 -> d=+2).
REQ-017 When a transfer completes and `req` is high in the same cycle, the block SHALL return to IDLE first; that `req` is lost.

Reset
REQ-018 `reset` SHALL act at any state, including mid-FREEZE or mid-SEND: state=IDLE, `busy`=0, `hid_read`=0, `out_valid`=0, `out_last`=0, `out_data`=0, byte index=0, last_x/last_y/last_wheel=0, report buffer=0.
REQ-019 After a reset the first report SHALL yield deltas relative to 0, saturated.

Configuration
REQ-020 Macro HID_WHEEL_EN:
- defined: REPORT_LEN=12, byte 11 = dwheel, last_wheel tracked.
- undefined: REPORT_LEN=11, `out_last` on byte 10, `hid_mouse_wheel` input present but ignored, no wheel logic synthesized.

Structure
REQ-021 Package `hid_report_pkg` SHALL hold the state enum, the byte-index constants, REPORT_LEN (conditional on HID_WHEEL_EN) and FREEZE_CYCLES=3.
REQ-022 A sub-module `hid_sat_delta8` (33-bit subtract, saturate to int8, output updated last) SHALL be instantiated once per axis.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- **Basic report:** req with kbd_conn=1, modifiers=0x02, keycodes={0x04,0,0,0,0,0}, x=5, y=-3, `out_ready`=1 -> bytes 80 02 04 00 00 00 00 00 00 05 FD [00]; `out_last` on last byte; `hid_read` high exactly 4 cycles.
- **Saturation and residual:** x=300 from last=0 -> dx=0x7F; second req with x unchanged -> dx=0x7F; third -> dx=0x2E (46); fourth -> 0x00.
- **Backpressure:** `out_ready` toggled 1/0 every cycle -> identical byte sequence, data stable during stalls, SEND lasts 2xREPORT_LEN-1 cycles.
- **Wrap:** last_y=0x7FFFFFFF, y=0x80000001 -> dy=0x02.
- **Reset mid-SEND:** reset asserted after byte 4 -> next cycle `out_valid`=0, `busy`=0, `hid_read`=0; following req with x=10 -> dx=0x0A.
- **Ignored req:** req pulsed during FREEZE and SEND -> exactly one report emitted; both macro settings run (11 vs 12 bytes).
